// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: fetch queue payload, state enum and default depth (fetch_queue honours FETCH_QUEUE_BYPASS_EN)
package fetch_queue_pkg;
  localparam int FETCH_QUEUE_DEPTH = 4;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_data_t;
  typedef enum logic {NORMAL, WAIT_SLOT} fq_state_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular fetch-to-decode buffer with flush and delay-slot-keeping flush; FETCH_QUEUE_BYPASS_EN enables empty-queue bypass
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FETCH_QUEUE_DEPTH,
  parameter type T = fetch_data_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_valid,
  input  T                       push_data,
  output logic                   push_ready,
  output logic                   pop_valid,
  output T                       pop_data,
  input  logic                   pop_ready,
  input  logic                   flush,
  input  logic                   flush_keep,
  output logic                   slot_pending,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  T              r_mem [DEPTH];
  logic [PW-1:0] r_rptr, r_wptr;
  logic [CW-1:0] r_count;
  fq_state_t     r_state;
  logic          w_empty, w_push, w_pop, w_bypass, w_store, w_deq, w_keep_old, w_has_h;
  logic [PW-1:0] w_hidx;
  assign w_empty = r_count == '0;
  assign push_ready = (r_state == WAIT_SLOT) || (r_count < CW'(DEPTH)) || pop_ready;
`ifdef FETCH_QUEUE_BYPASS_EN
  assign pop_valid = !w_empty || push_valid;
  assign pop_data = w_empty ? push_data : r_mem[r_rptr];
  assign w_bypass = w_empty && w_push && pop_ready;
`else
  assign pop_valid = !w_empty;
  assign pop_data = r_mem[r_rptr];
  assign w_bypass = 1'b0;
`endif
  assign w_push = push_valid && push_ready;
  assign w_pop = pop_valid && pop_ready;
  assign w_store = w_push && !w_bypass;
  assign w_deq = w_pop && !w_empty;
  // the survivor of flush_keep is the oldest entry left after this pop, else the entry being pushed
  assign w_keep_old = r_count > CW'(w_deq);
  assign w_has_h = w_keep_old || w_store;
  assign w_hidx = w_keep_old ? r_rptr + PW'(w_deq) : r_wptr;
  assign slot_pending = r_state == WAIT_SLOT;
  assign count = r_count;
  // pointers, occupancy and delay-slot state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
      r_state <= NORMAL;
    end else if (flush) begin
      r_rptr  <= r_wptr;
      r_count <= '0;
      r_state <= NORMAL;
    end else if (flush_keep && r_state == NORMAL) begin
      r_rptr  <= w_hidx;
      r_wptr  <= w_hidx + PW'(w_has_h);
      r_count <= w_has_h ? CW'(1) : '0;
      r_state <= w_has_h ? NORMAL : WAIT_SLOT;
    end else begin
      r_rptr  <= r_rptr + PW'(w_deq);
      r_wptr  <= r_wptr + PW'(w_store);
      r_count <= r_count + CW'(w_store) - CW'(w_deq);
      r_state <= w_push ? NORMAL : r_state;
    end
  end
  // payload storage; stale slots are never visible because occupancy gates them
  always_ff @(posedge clk) begin
    if (w_store) r_mem[r_wptr] <= push_data;
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed vectors against a queue-based reference model plus literal pins
module tb_fetch_queue;
  import fetch_queue_pkg::*;
  localparam int DEPTH = FETCH_QUEUE_DEPTH;
  logic clk = 1'b0, reset = 1'b1;
  logic push_valid = 1'b0, pop_ready = 1'b0, flush = 1'b0, flush_keep = 1'b0;
  fetch_data_t push_data = '0;
  fetch_data_t pop_data;
  logic push_ready, pop_valid, slot_pending;
  logic [$clog2(DEPTH):0] count;
  int nv = 0, nerr = 0;
  fetch_data_t mq[$];
  bit mwait = 1'b0;
  bit armed = 1'b0;

  fetch_queue dut (
    .clk(clk), .reset(reset), .push_valid(push_valid), .push_data(push_data),
    .push_ready(push_ready), .pop_valid(pop_valid), .pop_data(pop_data),
    .pop_ready(pop_ready), .flush(flush), .flush_keep(flush_keep),
    .slot_pending(slot_pending), .count(count)
  );

  always #5 clk = ~clk;

  function automatic fetch_data_t mk(input int n);
    fetch_data_t d;
    d.pc = 32'h0040_0000 + 32'(n) * 4;
    d.instr = 32'hA000_0000 + 32'(n);
    return d;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nv++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_pop_valid();
`ifdef FETCH_QUEUE_BYPASS_EN
    return mq.size() != 0 || push_valid;
`else
    return mq.size() != 0;
`endif
  endfunction

  // reference model: plain queue semantics evaluated at each rising edge
  always @(posedge clk) begin
    bit acc_push, acc_pop;
    fetch_data_t t[$];
    acc_push = push_valid && (mwait || mq.size() < DEPTH || pop_ready);
    acc_pop = m_pop_valid() && pop_ready;
    if (reset || flush) begin
      mq.delete();
      mwait = 1'b0;
      armed = 1'b1;
    end else begin
      t = mq;
      if (acc_pop && t.size() > 0) void'(t.pop_front());
      else if (acc_pop) acc_push = 1'b0;
      if (acc_push) t.push_back(push_data);
      if (flush_keep && !mwait) begin
        if (t.size() > 0) t = t[0:0];
        else mwait = 1'b1;
      end else if (push_valid) mwait = 1'b0;
      if (acc_pop && mq.size() == 0 && flush_keep == 1'b0 && push_valid) mwait = 1'b0;
      mq = t;
    end
  end

  // every-cycle comparison of the DUT outputs against the model
  always @(negedge clk) begin
    if (armed) begin
      chk("count", 64'(count), 64'(mq.size()));
      chk("push_ready", 64'(push_ready), 64'(mwait || mq.size() < DEPTH || pop_ready));
      chk("pop_valid", 64'(pop_valid), 64'(m_pop_valid()));
      chk("slot_pending", 64'(slot_pending), 64'(mwait));
      if (m_pop_valid()) chk("pop_data", pop_data, mq.size() != 0 ? mq[0] : push_data);
    end
  end

  task automatic cyc(input bit pv, input int n, input bit pr, input bit fl = 1'b0,
                     input bit fk = 1'b0, input bit rst = 1'b0);
    @(posedge clk);
    #1;
    push_valid = pv;
    push_data = mk(n);
    pop_ready = pr;
    flush = fl;
    flush_keep = fk;
    reset = rst;
    @(negedge clk);
    #1;
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_push_ready", 64'(push_ready), 64'd1);
    chk("rst_pop_valid", 64'(pop_valid), 64'd0);
    chk("rst_slot", 64'(slot_pending), 64'd0);
    for (int i = 1; i <= 4; i++) cyc(1, i, 0);
    cyc(1, 99, 0);
    chk("full_count", 64'(count), 64'd4);
    chk("full_push_ready", 64'(push_ready), 64'd0);
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 0, 1);
      chk("fifo_order", pop_data, mk(i));
    end
    cyc(0, 0, 0);
    chk("drained_count", 64'(count), 64'd0);
    for (int i = 1; i <= 4; i++) cyc(1, i, 0);
    cyc(1, 5, 1);
    chk("full_pushpop_ready", 64'(push_ready), 64'd1);
    chk("full_pushpop_head", pop_data, mk(1));
    cyc(0, 0, 0);
    chk("full_pushpop_count", 64'(count), 64'd4);
    for (int i = 2; i <= 5; i++) begin
      cyc(0, 0, 1);
      chk("after_e_order", pop_data, mk(i));
    end
    for (int i = 10; i <= 12; i++) cyc(1, i, 0);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 0);
    chk("keep_count", 64'(count), 64'd1);
    chk("keep_head", pop_data, mk(11));
    chk("keep_slot", 64'(slot_pending), 64'd0);
    cyc(0, 0, 1);
    cyc(1, 20, 0);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 0);
    chk("wait_count", 64'(count), 64'd0);
    chk("wait_slot", 64'(slot_pending), 64'd1);
    cyc(1, 21, 0);
    chk("wait_push_ready", 64'(push_ready), 64'd1);
    cyc(0, 0, 0);
    chk("slot_count", 64'(count), 64'd1);
    chk("slot_head", pop_data, mk(21));
    chk("slot_cleared", 64'(slot_pending), 64'd0);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0);
    chk("wait_ignores_keep", 64'(slot_pending), 64'd1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0);
    chk("wait_flush", 64'(slot_pending), 64'd0);
    for (int i = 30; i <= 32; i++) cyc(1, i, 0);
    cyc(1, 33, 1, 1, 1);
    cyc(0, 0, 0);
    chk("flush_prio_count", 64'(count), 64'd0);
    chk("flush_prio_slot", 64'(slot_pending), 64'd0);
    cyc(1, 40, 1, 0, 1);
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("bypass_valid", 64'(pop_valid), 64'd1);
    chk("bypass_data", pop_data, mk(40));
`else
    chk("nobypass_valid", 64'(pop_valid), 64'd0);
`endif
    cyc(0, 0, 0);
`ifndef FETCH_QUEUE_BYPASS_EN
    chk("keep_push_head", pop_data, mk(40));
    chk("keep_push_count", 64'(count), 64'd1);
`endif
    cyc(0, 0, 0, 1);
    cyc(1, 50, 0);
    cyc(1, 51, 0);
    cyc(1, 52, 1, 0, 0, 1);
    cyc(1, 53, 0);
    cyc(0, 0, 0);
    chk("post_reset_head", pop_data, mk(53));
    chk("post_reset_count", 64'(count), 64'd1);
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 3) != 0), 100 + i, 1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 12) == 0));
    $display("== %0d vectors applied, %0d miscompares ==", nv, nerr);
    $finish;
  end
endmodule
